// File: rtl/prbs_multilane_gen.sv
// Multi-lane PRBS DAC pattern generator: LANES samples per dac_clk, fractional bit-rate NCO, level mapping with saturation.
// Optional error injection is compiled in with `define PRBS_ERR_INJECT_EN.
module prbs_multilane_gen #(
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic                    dac_clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [2:0]              pn_select,
  input  logic [ACC_W-1:0]        bit_rate_inc,
  input  logic [DATA_W-2:0]       amplitude,
  input  logic [DATA_W-1:0]       dc_offset,
`ifdef PRBS_ERR_INJECT_EN
  input  logic                    err_inject,
  output logic                    err_inject_ack,
`endif
  output logic [LANES*DATA_W-1:0] dac_data,
  output logic                    dac_valid,
  output logic [LANES-1:0]        bits_out,
  output logic                    seq_wrap
);

  localparam int SW = 31;
  localparam logic signed [DATA_W:0] SAT_HI = {2'b00, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W:0] SAT_LO = {2'b11, {(DATA_W-1){1'b0}}};

  function automatic logic [4:0] pn_len(input logic [2:0] pn);
    case (pn)
      3'd1:    return 5'd9;
      3'd2:    return 5'd15;
      3'd3:    return 5'd23;
      3'd4:    return 5'd31;
      default: return 5'd7;
    endcase
  endfunction

  function automatic logic [4:0] pn_tap(input logic [2:0] pn);
    case (pn)
      3'd1:    return 5'd5;
      3'd2:    return 5'd14;
      3'd3:    return 5'd18;
      3'd4:    return 5'd28;
      default: return 5'd6;
    endcase
  endfunction

  // The seed doubles as the state mask: ones in the active bits, zeros above.
  function automatic logic [SW-1:0] pn_seed(input logic [2:0] pn);
    return (SW'(1) << pn_len(pn)) - SW'(1);
  endfunction

  logic [ACC_W-1:0] acc_reg, acc_c;
  logic [SW-1:0]    lfsr_reg, lfsr_c, seed_c;
  logic             cur_bit_reg, cur_c;
  logic [2:0]       pn_reg;
  logic [LANES-1:0] lane_bits_reg, lane_bits_c;
  logic             s1_valid_reg, s1_wrap_reg, wrap_c;
  logic             reseed_c, carry_c, fb_c;
  logic [4:0]       n_idx_c, m_idx_c;
`ifdef PRBS_ERR_INJECT_EN
  logic             err_armed_reg, err_fire_c, s1_ack_reg;
`endif

  // Stage 1: walk the LANES samples in order, each adding inc and stepping the LFSR on carry.
  always_comb begin
    reseed_c    = enable && (pn_select != pn_reg);
    seed_c      = pn_seed(pn_select);
    n_idx_c     = pn_len(pn_select) - 5'd1;
    m_idx_c     = pn_tap(pn_select) - 5'd1;
    lfsr_c      = seed_c;
    acc_c       = '0;
    cur_c       = 1'b0;
    lane_bits_c = '0;
    wrap_c      = 1'b0;
    carry_c     = 1'b0;
    fb_c        = 1'b0;
`ifdef PRBS_ERR_INJECT_EN
    err_fire_c  = 1'b0;
`endif
    if (enable) begin
      if (!reseed_c) begin
        lfsr_c = lfsr_reg;
        acc_c  = acc_reg;
        cur_c  = cur_bit_reg;
      end
      for (int k = 0; k < LANES; k++) begin
        {carry_c, acc_c} = {1'b0, acc_c} + {1'b0, bit_rate_inc};
        if (carry_c) begin
          fb_c   = lfsr_c[n_idx_c] ^ lfsr_c[m_idx_c];
          lfsr_c = {lfsr_c[SW-2:0], fb_c} & seed_c;
          cur_c  = fb_c;
          if (lfsr_c == seed_c) wrap_c = 1'b1;
`ifdef PRBS_ERR_INJECT_EN
          if (err_armed_reg && !reseed_c && !err_fire_c) begin
            cur_c      = ~fb_c;
            err_fire_c = 1'b1;
          end
`endif
        end
        lane_bits_c[k] = cur_c;
      end
    end
  end

  always_ff @(posedge dac_clk) begin
    if (!reset_n) begin
      acc_reg       <= '0;
      lfsr_reg      <= pn_seed(3'd0);
      cur_bit_reg   <= 1'b0;
      pn_reg        <= 3'd0;
      lane_bits_reg <= '0;
      s1_valid_reg  <= 1'b0;
      s1_wrap_reg   <= 1'b0;
`ifdef PRBS_ERR_INJECT_EN
      err_armed_reg <= 1'b0;
      s1_ack_reg    <= 1'b0;
`endif
    end else begin
      acc_reg       <= acc_c;
      lfsr_reg      <= lfsr_c;
      cur_bit_reg   <= cur_c;
      pn_reg        <= pn_select;
      lane_bits_reg <= lane_bits_c;
      s1_valid_reg  <= enable;
      s1_wrap_reg   <= wrap_c;
`ifdef PRBS_ERR_INJECT_EN
      s1_ack_reg    <= err_fire_c;
      if (!enable || reseed_c || err_fire_c) err_armed_reg <= 1'b0;
      else if (!err_armed_reg)               err_armed_reg <= err_inject;
`endif
    end
  end

  // Stage 2 level mapping; amplitude and offset are taken live so changes land on the next clock.
  logic [DATA_W-1:0] level_c [LANES];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_map
    logic signed [DATA_W:0] sum;
    assign sum = lane_bits_reg[gi]
               ? $signed({dc_offset[DATA_W-1], dc_offset}) + $signed({2'b00, amplitude})
               : $signed({dc_offset[DATA_W-1], dc_offset}) - $signed({2'b00, amplitude});
    assign level_c[gi] = !s1_valid_reg  ? dc_offset
                       : (sum > SAT_HI) ? SAT_HI[DATA_W-1:0]
                       : (sum < SAT_LO) ? SAT_LO[DATA_W-1:0]
                       : sum[DATA_W-1:0];
  end

  always_ff @(posedge dac_clk) begin
    if (!reset_n) begin
      dac_data       <= '0;
      dac_valid      <= 1'b0;
      bits_out       <= '0;
      seq_wrap       <= 1'b0;
`ifdef PRBS_ERR_INJECT_EN
      err_inject_ack <= 1'b0;
`endif
    end else begin
      for (int k = 0; k < LANES; k++) dac_data[k*DATA_W +: DATA_W] <= level_c[k];
      dac_valid      <= s1_valid_reg;
      bits_out       <= s1_valid_reg ? lane_bits_reg : '0;
      seq_wrap       <= s1_wrap_reg;
`ifdef PRBS_ERR_INJECT_EN
      err_inject_ack <= s1_ack_reg;
`endif
    end
  end

endmodule

// File: tb/tb_prbs_multilane_gen.sv
// Bench for prbs_multilane_gen: behavioural model (integer NCO, step-counted sequence position) checked every cycle.
// Error-injection checks are compiled when PRBS_ERR_INJECT_EN is defined.
module tb_prbs_multilane_gen;
  localparam int LANES = 4, DATA_W = 16, ACC_W = 32;

  logic dac_clk = 1'b0;
  logic reset_n, enable;
  logic [2:0] pn_select;
  logic [ACC_W-1:0] bit_rate_inc;
  logic [DATA_W-2:0] amplitude;
  logic [DATA_W-1:0] dc_offset;
  logic [LANES*DATA_W-1:0] dac_data;
  logic dac_valid, seq_wrap;
  logic [LANES-1:0] bits_out;
`ifdef PRBS_ERR_INJECT_EN
  logic err_inject, err_inject_ack;
`endif

  prbs_multilane_gen #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .dac_clk(dac_clk), .reset_n(reset_n), .enable(enable), .pn_select(pn_select),
    .bit_rate_inc(bit_rate_inc), .amplitude(amplitude), .dc_offset(dc_offset),
`ifdef PRBS_ERR_INJECT_EN
    .err_inject(err_inject), .err_inject_ack(err_inject_ack),
`endif
    .dac_data(dac_data), .dac_valid(dac_valid), .bits_out(bits_out), .seq_wrap(seq_wrap)
  );

  always #5 dac_clk = ~dac_clk;

  int total = 0, bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pn_n(input int pn);
    case (pn) 1: return 9; 2: return 15; 3: return 23; 4: return 31; default: return 7; endcase
  endfunction
  function automatic int pn_m(input int pn);
    case (pn) 1: return 5; 2: return 14; 3: return 18; 4: return 28; default: return 6; endcase
  endfunction
  function automatic logic [15:0] level(input bit b, input int amp, input int off);
    int v;
    v = off + (b ? amp : -amp);
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return 16'(v);
  endfunction

  // Model state: accumulator as a plain integer, sequence position counted in steps since seed.
  longint m_acc, m_lfsr, m_steps, a;
  int m_pn;
  bit m_cur, m_armed, fired, reseed, b;
  bit s1_valid, s1_wrap, s1_ack;
  bit [LANES-1:0] s1_bits;
  logic [63:0] e_data;
  logic [LANES-1:0] e_bits;
  logic e_valid, e_wrap, e_ack;

  task automatic model_reseed();
    m_acc = 0; m_cur = 0; m_steps = 0;
    m_lfsr = (longint'(1) << pn_n(int'(pn_select))) - 1;
  endtask

  always @(posedge dac_clk) begin
    if (!reset_n) begin
      m_pn = 0; m_armed = 0;
      m_acc = 0; m_cur = 0; m_steps = 0; m_lfsr = 127;
      s1_valid = 0; s1_wrap = 0; s1_ack = 0; s1_bits = '0;
      e_data = '0; e_bits = '0; e_valid = 0; e_wrap = 0; e_ack = 0;
    end else begin
      e_valid = s1_valid; e_wrap = s1_wrap; e_ack = s1_ack;
      for (int k = 0; k < LANES; k++) begin
        e_bits[k] = s1_valid ? s1_bits[k] : 1'b0;
        e_data[k*16 +: 16] = s1_valid ? level(s1_bits[k], int'(amplitude), int'($signed(dc_offset)))
                                      : dc_offset;
      end
      if (!enable) begin
        model_reseed();
        s1_valid = 0; s1_bits = '0; s1_wrap = 0; s1_ack = 0; m_armed = 0;
      end else begin
        int n, m;
        longint period;
        n = pn_n(int'(pn_select)); m = pn_m(int'(pn_select));
        period = (longint'(1) << n) - 1;
        reseed = (int'(pn_select) != m_pn);
        if (reseed) model_reseed();
        fired = 0; s1_wrap = 0;
        for (int k = 0; k < LANES; k++) begin
          a = m_acc + longint'(bit_rate_inc);
          if (a >= (longint'(1) << ACC_W)) begin
            m_acc = a - (longint'(1) << ACC_W);
            b = bit'(((m_lfsr >> (n - 1)) ^ (m_lfsr >> (m - 1))) & 1);
            m_lfsr = ((m_lfsr << 1) | longint'(b)) & period;
            m_steps++;
            if (m_steps % period == 0) s1_wrap = 1;
            m_cur = b;
            if (m_armed && !reseed && !fired) begin m_cur = !b; fired = 1; end
          end else m_acc = a;
          s1_bits[k] = m_cur;
        end
        s1_valid = 1; s1_ack = fired;
`ifdef PRBS_ERR_INJECT_EN
        if (reseed || fired) m_armed = 0;
        else if (!m_armed) m_armed = err_inject;
`endif
      end
      m_pn = int'(pn_select);
    end
  end

  always @(negedge dac_clk) begin
    if (chk_on) begin
      chk("dac_data", dac_data, e_data);
      chk("dac_valid", 64'(dac_valid), 64'(e_valid));
      chk("bits_out", 64'(bits_out), 64'(e_bits));
      chk("seq_wrap", 64'(seq_wrap), 64'(e_wrap));
`ifdef PRBS_ERR_INJECT_EN
      chk("err_ack", 64'(err_inject_ack), 64'(e_ack));
`endif
    end
  end

  task automatic tick();
    @(posedge dac_clk);
    @(negedge dac_clk);
  endtask

  initial begin
    int w1, w2, acks;
    reset_n = 0; enable = 0; pn_select = 0; bit_rate_inc = 0; amplitude = 0; dc_offset = 0;
`ifdef PRBS_ERR_INJECT_EN
    err_inject = 0;
`endif
    @(negedge dac_clk); chk_on = 1;
    tick();
    chk("rst_valid", 64'(dac_valid), 64'd0);
    chk("rst_data", dac_data, 64'd0);

    // PN7 at full rate: latency, first groups, wrap spacing.
    reset_n = 1; enable = 1; pn_select = 0; bit_rate_inc = '1; amplitude = 15'h4000; dc_offset = 0;
    tick(); chk("lat1_valid", 64'(dac_valid), 64'd0);
    tick(); chk("lat2_valid", 64'(dac_valid), 64'd1); chk("g0_bits", 64'(bits_out), 64'd0);
    tick(); chk("g1_bits", 64'(bits_out), 64'b1000);
    chk("g1_data", dac_data, 64'h4000_C000_C000_C000);
    w1 = 0; w2 = 0;
    for (int t = 4; t <= 200; t++) begin
      tick();
      if (seq_wrap && w1 == 0) w1 = t;
      else if (seq_wrap && w2 == 0) w2 = t;
    end
    chk("pn7_wrap1", 64'(w1), 64'd33);
    chk("pn7_wrap_gap", 64'(w2 - w1), 64'd32);

    // PN9 at half rate.
    pn_select = 1; bit_rate_inc = 32'h8000_0000;
    repeat (40) tick();

    // Disable: valid falls two clocks later, data is the raw offset.
    amplitude = 15'h7FFF; dc_offset = 16'h7000; enable = 0;
    tick(); chk("dis1_valid", 64'(dac_valid), 64'd1);
    tick(); chk("dis2_valid", 64'(dac_valid), 64'd0);
    chk("dis_data", dac_data, {4{16'h7000}});

    // Frozen bit 0 with saturation.
    bit_rate_inc = 0; enable = 1;
    tick(); tick();
    chk("frozen_f001", dac_data, {4{16'hF001}});
    dc_offset = 16'h9000;
    tick(); chk("sat_low", dac_data, {4{16'h8000}});
    dc_offset = 16'h7000; bit_rate_inc = '1;
    repeat (40) tick();

    // Mid-run polynomial change restarts from seed without a wrap pulse.
    pn_select = 1; amplitude = 15'h1234; dc_offset = 0;
    repeat (20) tick();
    pn_select = 3;
    tick(); chk("pnchg_wrap1", 64'(seq_wrap), 64'd0);
    tick(); chk("pnchg_bits", 64'(bits_out), 64'd0); chk("pnchg_wrap2", 64'(seq_wrap), 64'd0);
    repeat (30) tick();

    // PN15 full period.
    enable = 0; tick();
    enable = 1; pn_select = 2; w1 = 0;
    for (int t = 1; t <= 9000 && w1 == 0; t++) begin
      tick();
      if (seq_wrap) w1 = t;
    end
    chk("pn15_wrap", 64'(w1), 64'd8193);

`ifdef PRBS_ERR_INJECT_EN
    pn_select = 0; bit_rate_inc = '1;
    repeat (10) tick();
    acks = 0;
    err_inject = 1; tick(); tick(); err_inject = 0;
    for (int t = 0; t < 12; t++) begin
      if (err_inject_ack) acks++;
      tick();
    end
    chk("inj_ack_count", 64'(acks), 64'd1);
`else
    acks = 0;
`endif

    // Randomised run including resets.
    for (int t = 0; t < 3000; t++) begin
      reset_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 63) == 0) enable = ~enable;
      if ($urandom_range(0, 63) == 0) pn_select = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 47) == 0)
        case ($urandom_range(0, 3))
          0: bit_rate_inc = 0;
          1: bit_rate_inc = 32'h8000_0000;
          2: bit_rate_inc = '1;
          default: bit_rate_inc = $urandom;
        endcase
      if ($urandom_range(0, 31) == 0) amplitude = 15'($urandom);
      if ($urandom_range(0, 31) == 0) dc_offset = 16'($urandom);
`ifdef PRBS_ERR_INJECT_EN
      err_inject = ($urandom_range(0, 15) == 0);
`endif
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
